// File: rtl/ahb_slave_if.sv
// AHB-lite slave front end. It turns pipelined AHB address/data phases into one outstanding
// local request, inserts wait states, and answers with OKAY or the two-cycle ERROR response.
module ahb_slave_if #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned WAIT_TIMEOUT   = 16
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rstn_in,
    input  logic                      ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]                ahb_trans_in,
    input  logic                      ahb_write_in,
    input  logic [2:0]                ahb_size_in,
    input  logic [2:0]                ahb_burst_in,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
    input  logic                      ahb_ready_in,
    output logic                      ahb_readyout_out,
    output logic                      ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
    output logic                      other_valid_out,
    output logic                      other_write_out,
    output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
    output logic [2:0]                other_size_out,
    output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
    input  logic                      other_ready_in,
    input  logic                      other_error_in,
    input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

    localparam int unsigned AW = AHB_ADDR_WIDTH;
    localparam int unsigned DW = AHB_DATA_WIDTH;
    localparam int unsigned CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam int unsigned XW = 11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ERR1   = 2'd2,
        S_ERR2   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] rdata_q;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;

    logic [XW-1:0] xfer_bits;
    logic [AW-1:0] align_mask;
    logic          accept;
    logic          illegal;
    logic          in_access;
    logic          timeout;
    logic          done;
    logic          fail;
    logic          sample;
    logic          enter_access;
    logic          unused_inputs;

    // Address-phase decode: transfer width in bits and the low-address alignment mask
    assign xfer_bits  = XW'(8) << ahb_size_in;
    assign align_mask = ~({AW{1'b1}} << ahb_size_in);
    assign accept     = ahb_sel_in && ahb_ready_in && ahb_trans_in[1];
    assign illegal    = (xfer_bits > XW'(DW)) || ((ahb_addr_in & align_mask) != '0);

    // Timeout only fires on a cycle the local side is still stalling, so a late ready wins
    assign in_access    = (state == S_ACCESS);
    assign timeout      = (WAIT_TIMEOUT != 0) && !other_ready_in
                          && (wait_cnt == CW'(WAIT_TIMEOUT));
    assign done         = in_access && other_ready_in && !other_error_in;
    assign fail         = in_access && ((other_ready_in && other_error_in) || timeout);
    assign sample       = accept && ((state == S_IDLE) || (state == S_ERR2) || done);
    assign enter_access = sample && !illegal;

    assign unused_inputs = ^{ahb_burst_in, ahb_trans_in[0]};

    // State register
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    state_nxt = illegal ? S_ERR1 : S_ACCESS;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (fail) begin
                    state_nxt = S_ERR1;
                end else if (done) begin
                    if (accept) begin
                        state_nxt = illegal ? S_ERR1 : S_ACCESS;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; HREADYOUT follows the local handshake directly so zero-wait works
    always_comb begin
        ahb_readyout_out = 1'b1;
        ahb_resp_out     = 1'b0;
        other_valid_out  = 1'b0;
        other_wdata_out  = '0;
        ahb_rdata_out    = rdata_q;
        case (state)
            S_ACCESS: begin
                ahb_readyout_out = other_ready_in && !other_error_in;
                other_valid_out  = 1'b1;
                other_wdata_out  = ahb_wdata_in;
                if (done) begin
                    ahb_rdata_out = req_write ? '0 : other_rdata_in;
                end
            end
            S_ERR1: begin
                ahb_readyout_out = 1'b0;
                ahb_resp_out     = 1'b1;
            end
            S_ERR2: begin
                ahb_resp_out = 1'b1;
            end
            default: begin
                ahb_readyout_out = 1'b1;
            end
        endcase
    end

    // Request capture, read-data hold and wait counter
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_size  <= '0;
            rdata_q   <= '0;
            wait_cnt  <= '0;
        end else begin
            if (enter_access) begin
                req_write <= ahb_write_in;
                req_addr  <= ahb_addr_in;
                req_size  <= ahb_size_in;
            end
            if (done && !req_write) begin
                rdata_q <= other_rdata_in;
            end
            if (enter_access) begin
                wait_cnt <= '0;
            end else if (in_access && !other_ready_in && (wait_cnt != CW'(WAIT_TIMEOUT))) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    assign other_write_out = req_write;
    assign other_addr_out  = req_addr;
    assign other_size_out  = req_size;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: directed table of transfers, hand-written reset sequence, then
// random transfers checked against a transfer-level response model.
module tb_ahb_slave_if;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int K_NONE     = 0;
    localparam int K_OK       = 1;
    localparam int K_ILLEGAL  = 2;
    localparam int K_LOCALERR = 3;
    localparam int K_TIMEOUT  = 4;
    localparam int NUM_VEC    = 14;
    localparam int NUM_RAND   = 300;

    typedef struct {
        logic              sel;
        logic [1:0]        trans;
        logic              write;
        logic [2:0]        size;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     wdata;
        int unsigned       delay;
        logic              err;
        logic [DW-1:0]     rdata;
        int                kind;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          ahb_sel_in;
    logic [AW-1:0] ahb_addr_in;
    logic [1:0]    ahb_trans_in;
    logic          ahb_write_in;
    logic [2:0]    ahb_size_in;
    logic [2:0]    ahb_burst_in;
    logic [DW-1:0] ahb_wdata_in;
    logic          ahb_ready_in;
    logic          ahb_readyout_out;
    logic          ahb_resp_out;
    logic [DW-1:0] ahb_rdata_out;
    logic          other_valid_out;
    logic          other_write_out;
    logic [AW-1:0] other_addr_out;
    logic [2:0]    other_size_out;
    logic [DW-1:0] other_wdata_out;
    logic          other_ready_in;
    logic          other_error_in;
    logic [DW-1:0] other_rdata_in;

    int tests;
    int fails;
    vec_t tbl [NUM_VEC];

    // Single slave on the bus: HREADY is this slave's own HREADYOUT
    assign ahb_ready_in = ahb_readyout_out;

    ahb_slave_if #(
        .AHB_ADDR_WIDTH(AW),
        .AHB_DATA_WIDTH(DW),
        .WAIT_TIMEOUT  (TIMEOUT)
    ) dut (
        .ahb_clk_in      (clk),
        .ahb_rstn_in     (rst_n),
        .ahb_sel_in      (ahb_sel_in),
        .ahb_addr_in     (ahb_addr_in),
        .ahb_trans_in    (ahb_trans_in),
        .ahb_write_in    (ahb_write_in),
        .ahb_size_in     (ahb_size_in),
        .ahb_burst_in    (ahb_burst_in),
        .ahb_wdata_in    (ahb_wdata_in),
        .ahb_ready_in    (ahb_ready_in),
        .ahb_readyout_out(ahb_readyout_out),
        .ahb_resp_out    (ahb_resp_out),
        .ahb_rdata_out   (ahb_rdata_out),
        .other_valid_out (other_valid_out),
        .other_write_out (other_write_out),
        .other_addr_out  (other_addr_out),
        .other_size_out  (other_size_out),
        .other_wdata_out (other_wdata_out),
        .other_ready_in  (other_ready_in),
        .other_error_in  (other_error_in),
        .other_rdata_in  (other_rdata_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic p, input logic v);
        chk({tag, " ready/resp/valid"},
            64'({ahb_readyout_out, ahb_resp_out, other_valid_out}), 64'({r, p, v}));
    endtask

    task automatic chk_req(input string tag, input vec_t c);
        chk({tag, " req write/size/addr"},
            64'({other_write_out, other_size_out, other_addr_out}),
            64'({c.write, c.size, c.addr}));
        chk({tag, " req wdata"}, 64'(other_wdata_out), 64'(c.wdata));
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic write,
                                input logic [2:0] size, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int unsigned delay,
                                input logic err, input logic [DW-1:0] rdata, input int kind);
        vec_t v;
        v.sel = sel; v.trans = trans; v.write = write; v.size = size; v.addr = addr;
        v.wdata = wdata; v.delay = delay; v.err = err; v.rdata = rdata; v.kind = kind;
        return v;
    endfunction

    // Reference model: outcome of a transfer from the bus rules alone
    function automatic int kind_of(input vec_t v);
        int unsigned bytes;
        if (!(v.sel && v.trans >= 2'd2)) return K_NONE;
        bytes = 32'd1 << v.size;
        if (bytes * 8 > DW || (v.addr % bytes) != 0) return K_ILLEGAL;
        if (v.delay > TIMEOUT) return K_TIMEOUT;
        if (v.err) return K_LOCALERR;
        return K_OK;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int unsigned r;
        v.sel = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        v.trans = (r < 2) ? 2'd0 : (r < 3) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
        v.write = 1'($urandom_range(0, 1));
        v.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        v.addr = $urandom;
        if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
        v.wdata = $urandom;
        v.rdata = $urandom;
        v.err = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 9);
        v.delay = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 4) : $urandom_range(15, 18);
        v.kind = K_NONE;
        return v;
    endfunction

    task automatic drive_addr(input vec_t v);
        ahb_sel_in   = v.sel;
        ahb_trans_in = v.trans;
        ahb_write_in = v.write;
        ahb_size_in  = v.size;
        ahb_addr_in  = v.addr;
        ahb_burst_in = 3'($urandom_range(0, 7));
    endtask

    task automatic err_tail(input string tag);
        @(negedge clk); chk_bus({tag, " err1"}, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk_bus({tag, " err2"}, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
    endtask

    // Data phase of one transfer; entered and left at posedge+1
    task automatic run_dp(input vec_t c, input int kind, input string tag);
        int unsigned nwait;
        other_ready_in = 1'b0;
        other_error_in = 1'b0;
        ahb_wdata_in   = c.wdata;
        if (kind == K_NONE) begin
            @(negedge clk); chk_bus({tag, " none"}, 1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end else if (kind == K_ILLEGAL) begin
            err_tail(tag);
        end else begin
            nwait = (kind == K_TIMEOUT) ? TIMEOUT + 1 : c.delay;
            for (int unsigned k = 0; k < nwait; k++) begin
                other_rdata_in = $urandom;
                @(negedge clk);
                chk_bus({tag, " wait"}, 1'b0, 1'b0, 1'b1);
                chk_req(tag, c);
                @(posedge clk); #1;
            end
            if (kind != K_TIMEOUT) begin
                other_ready_in = 1'b1;
                other_error_in = (kind == K_LOCALERR);
                other_rdata_in = c.rdata;
                @(negedge clk);
                chk_bus({tag, " done"}, (kind == K_OK), 1'b0, 1'b1);
                chk_req(tag, c);
                if (kind == K_OK && !c.write) chk({tag, " rdata"}, 64'(ahb_rdata_out), 64'(c.rdata));
                @(posedge clk); #1;
                other_ready_in = 1'b0;
                other_error_in = 1'b0;
            end
            if (kind != K_OK) err_tail(tag);
        end
    endtask

    initial begin
        vec_t idle;
        vec_t cur;
        vec_t nxt;
        int   cur_kind;
        tests = 0;
        fails = 0;

        tbl[0]  = mk(1, 2'd2, 1, 3'd2, 32'h10, 32'hA5A5_A5A5, 0,  0, 32'h0,         K_OK);
        tbl[1]  = mk(1, 2'd3, 0, 3'd2, 32'h14, 32'h0,        0,  0, 32'h1234_5678, K_OK);
        tbl[2]  = mk(1, 2'd2, 0, 3'd2, 32'h20, 32'h0,        3,  0, 32'hCAFE_0001, K_OK);
        tbl[3]  = mk(1, 2'd2, 0, 3'd3, 32'h00, 32'h0,        0,  0, 32'h0,         K_ILLEGAL);
        tbl[4]  = mk(1, 2'd2, 0, 3'd2, 32'h02, 32'h0,        0,  0, 32'h0,         K_ILLEGAL);
        tbl[5]  = mk(1, 2'd2, 1, 3'd2, 32'h30, 32'h1111_2222, 20, 0, 32'h0,        K_TIMEOUT);
        tbl[6]  = mk(1, 2'd1, 0, 3'd2, 32'h40, 32'h0,        0,  0, 32'h0,         K_NONE);
        tbl[7]  = mk(1, 2'd0, 0, 3'd2, 32'h40, 32'h0,        0,  0, 32'h0,         K_NONE);
        tbl[8]  = mk(0, 2'd2, 1, 3'd2, 32'h44, 32'h0,        0,  0, 32'h0,         K_NONE);
        tbl[9]  = mk(1, 2'd2, 0, 3'd1, 32'h40, 32'h0,        1,  1, 32'hDEAD,      K_LOCALERR);
        tbl[10] = mk(1, 2'd2, 0, 3'd0, 32'h03, 32'h0,        0,  0, 32'h89AB_CDEF, K_OK);
        tbl[11] = mk(1, 2'd3, 1, 3'd2, 32'h44, 32'h5A5A_0F0F, 16, 0, 32'h0,        K_OK);
        tbl[12] = mk(1, 2'd2, 1, 3'd2, 32'h48, 32'h0BAD_F00D, 17, 0, 32'h0,        K_TIMEOUT);
        tbl[13] = mk(1, 2'd2, 0, 3'd2, 32'h4C, 32'h0,        2,  0, 32'h7777_8888, K_OK);

        idle = mk(0, 2'd0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0, K_NONE);
        drive_addr(idle);
        ahb_wdata_in   = '0;
        other_ready_in = 1'b0;
        other_error_in = 1'b0;
        other_rdata_in = '0;
        rst_n = 1'b0;

        #12;
        chk_bus("reset", 1'b1, 1'b0, 1'b0);
        chk("reset rdata", 64'(ahb_rdata_out), 64'h0);
        chk("reset req", 64'({other_write_out, other_size_out, other_addr_out}), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table, pipelined: next address phase overlaps current data phase
        cur = idle;
        cur_kind = K_NONE;
        for (int i = 0; i < NUM_VEC; i++) begin
            drive_addr(tbl[i]);
            run_dp(cur, cur_kind, $sformatf("vec%0d", i - 1));
            cur = tbl[i];
            cur_kind = tbl[i].kind;
        end
        drive_addr(idle);
        run_dp(cur, cur_kind, "vec13");
        run_dp(idle, K_NONE, "tail");
        chk("rdata hold", 64'(ahb_rdata_out), 64'h7777_8888);

        // Reset asserted in the middle of a stalled access
        drive_addr(mk(1, 2'd2, 0, 3'd2, 32'h50, 32'h0, 0, 0, 32'h0, K_OK));
        other_ready_in = 1'b0;
        @(posedge clk); #1;
        drive_addr(idle);
        @(negedge clk);
        chk_bus("midrst pre", 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bus("midrst", 1'b1, 1'b0, 1'b0);
        chk("midrst addr", 64'(other_addr_out), 64'h0);
        chk("midrst rdata", 64'(ahb_rdata_out), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random transfers against the model
        cur = idle;
        cur_kind = K_NONE;
        for (int i = 0; i < NUM_RAND; i++) begin
            nxt = rand_vec();
            drive_addr(nxt);
            run_dp(cur, cur_kind, $sformatf("rnd%0d", i - 1));
            cur = nxt;
            cur_kind = kind_of(nxt);
        end
        drive_addr(idle);
        run_dp(cur, cur_kind, "rnd_last");
        run_dp(idle, K_NONE, "rnd_tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
